// File: rtl/phrase_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phrase_streamer_pkg
// Purpose  : Shared types and constants for the phrase RAM read sequencer.
//            - ps_state_t   : sequencer state encoding
//            - PS_RAM_DEPTH : number of words in the phrase RAM
//            - PS_TERM_WORD : word value that ends a run when
//                             PHRASE_STREAMER_TERM_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
package phrase_streamer_pkg;

  localparam int          PS_RAM_DEPTH = 328;
  localparam logic [31:0] PS_TERM_WORD = 32'h0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    LATCH = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } ps_state_t;

endpackage
`default_nettype wire

// File: rtl/phrase_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : phrase_streamer_if
// Purpose  : Bundles the RAM read port and the downstream valid/ready word
//            stream of phrase_streamer.
//   RAM side   : ram_address, ram_wren, ram_data (to RAM), ram_q (from RAM)
//   Stream side: out_data, out_valid (to consumer), out_ready (from consumer)
//   modport master : the sequencer
//   modport slave  : the RAM + consumer environment
// Revision : 1.0 - initial release
// ============================================================================
interface phrase_streamer_if #(
  parameter int DW = 32,
  parameter int AW = 32
);

  logic [AW-1:0] ram_address;
  logic          ram_wren;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output ram_address,
    output ram_wren,
    output ram_data,
    output out_data,
    output out_valid,
    input  ram_q,
    input  out_ready
  );

  modport slave (
    input  ram_address,
    input  ram_wren,
    input  ram_data,
    input  out_data,
    input  out_valid,
    output ram_q,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/phrase_addr_ctr.sv
`default_nettype none
// ============================================================================
// Module   : phrase_addr_ctr
// Purpose  : Loadable wrap-around RAM address counter.
//   clock, reset : clock / asynchronous active-high reset
//   load         : load load_addr (values >= DEPTH are replaced by 0)
//   load_addr    : address to load
//   advance      : step the address by one, DEPTH-1 wraps to 0
//   addr         : registered address
// Revision : 1.0 - initial release
// ============================================================================
module phrase_addr_ctr #(
  parameter int DEPTH = 328,
  parameter int AW    = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic          advance,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] C_DEPTH = AW'(DEPTH);
  localparam logic [AW-1:0] C_LAST  = AW'(DEPTH - 1);

  logic [AW-1:0] r_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
    end else if (load) begin
      // Out-of-range bases start the walk at the first word
      r_addr <= (load_addr >= C_DEPTH) ? '0 : load_addr;
    end else if (advance) begin
      r_addr <= (r_addr == C_LAST) ? '0 : r_addr + AW'(1);
    end
  end

  assign addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/phrase_streamer.sv
`default_nettype none
// ============================================================================
// Module   : phrase_streamer
// Purpose  : Walks a contiguous range of the phrase RAM and presents each
//            word on a valid/ready stream. Owns the RAM port (never writes).
//   clock, reset : clock / asynchronous active-high reset
//   start        : begin a run (only sampled while idle)
//   base_addr    : first word address, latched on accepted start
//   length       : number of words, latched on accepted start
//   busy         : high whenever the sequencer is not idle
//   done         : one-cycle pulse at the end of a run
//   bus          : phrase_streamer_if.master (RAM port + output stream)
// Build option:
//   PHRASE_STREAMER_TERM_EN - an all-zero RAM word ends the run early and
//                             is not emitted.
// Revision : 1.0 - initial release
// ============================================================================
module phrase_streamer
  import phrase_streamer_pkg::*;
#(
  parameter int DEPTH = PS_RAM_DEPTH,
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int LEN_W = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  phrase_streamer_if.master bus
);

`ifdef PHRASE_STREAMER_TERM_EN
  localparam bit C_TERM_EN = 1'b1;
`else
  localparam bit C_TERM_EN = 1'b0;
`endif

  ps_state_t        r_state;
  ps_state_t        w_state_nxt;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_count_nxt;
  logic [DW-1:0]    r_out_data;
  logic [DW-1:0]    w_data_nxt;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;
  logic             w_load;
  logic             w_advance;
  logic [AW-1:0]    w_addr;

  phrase_addr_ctr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_addr_ctr (
    .clock     (clock),
    .reset     (reset),
    .load      (w_load),
    .load_addr (base_addr),
    .advance   (w_advance),
    .addr      (w_addr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_out_data  <= w_data_nxt;
      // Flags are decoded from the next state so they are registered
      // and line up exactly with the state they describe.
      r_out_valid <= (w_state_nxt == HOLD);
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= (w_state_nxt == DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_data_nxt  = r_out_data;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            w_load      = 1'b1;
            w_count_nxt = length;
            w_state_nxt = RD;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      // Address is already on the RAM; its read data lands during LATCH
      RD: w_state_nxt = LATCH;
      LATCH: begin
        if (C_TERM_EN && (bus.ram_q == DW'(PS_TERM_WORD))) begin
          w_state_nxt = DONE;
        end else begin
          w_data_nxt  = bus.ram_q;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (r_out_valid && bus.out_ready) begin
          w_advance = 1'b1;
          if (r_count != '0) begin
            w_count_nxt = r_count - LEN_W'(1);
          end
          w_state_nxt = (r_count <= LEN_W'(1)) ? DONE : RD;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.ram_address = w_addr;
  assign bus.ram_wren    = 1'b0;
  assign bus.ram_data    = '0;
  assign bus.out_data    = r_out_data;
  assign bus.out_valid   = r_out_valid;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_phrase_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_phrase_streamer
// Purpose  : Self-checking bench for phrase_streamer with a behavioural
//            RAM model and a list-based reference of the expected stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phrase_streamer;
  import phrase_streamer_pkg::*;

  localparam int DEPTH = 328;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int LEN_W = 9;
  localparam int RUN_LIMIT = 5000;

`ifdef PHRASE_STREAMER_TERM_EN
  localparam bit TERM_EN = 1'b1;
`else
  localparam bit TERM_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [LEN_W-1:0] length = '0;
  logic             busy;
  logic             done;

  phrase_streamer_if #(.DW(DW), .AW(AW)) bus ();

  phrase_streamer #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW),
    .LEN_W (LEN_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  // RAM: registered read, data valid one clock after the address edge
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (bus.ram_address < AW'(DEPTH)) bus.ram_q <= mem[bus.ram_address];
    else                              bus.ram_q <= '0;
  end

  // Monitor: a transfer happens at the posedge following a negedge where
  // valid and ready are both high (inputs only change just after posedge).
  logic [DW-1:0] got [$];
  int            done_cnt = 0;
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      if (done) done_cnt++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: list of words a run must produce
  logic [DW-1:0] exp_q [$];
  function automatic void build_exp(input logic [AW-1:0] b, input int len);
    int a;
    a = (b >= AW'(DEPTH)) ? 0 : int'(b);
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      if (TERM_EN && mem[a] == '0) break;
      exp_q.push_back(mem[a]);
      a = (a + 1) % DEPTH;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic compare_words(input string name, input int first);
    int n;
    int bad;
    n   = got.size() - first;
    bad = 0;
    check({name, " word count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      if (got[first+i] !== exp_q[i]) bad++;
    check({name, " word mismatches"}, 64'(bad), 64'd0);
  endtask

  // Full run from idle; caller is positioned just after a posedge.
  task automatic do_run(input string name, input logic [AW-1:0] b, input int len,
                        input int rpct, input bit poke, output int first);
    int d0;
    int cyc;
    first = got.size();
    d0    = done_cnt;
    cyc   = 0;
    build_exp(b, len);
    start     = 1'b1;
    base_addr = b;
    length    = LEN_W'(len);
    bus.out_ready = ($urandom_range(99) < rpct);
    tick();
    start     = 1'b0;
    base_addr = $urandom;
    length    = LEN_W'($urandom);
    while (busy && cyc < RUN_LIMIT) begin
      bus.out_ready = ($urandom_range(99) < rpct);
      start = poke && ($urandom_range(7) == 0);
      tick();
      cyc++;
    end
    start = 1'b0;
    check({name, " timeout"}, 64'(cyc >= RUN_LIMIT), 64'd0);
    compare_words(name, first);
    check({name, " done pulses"}, 64'(done_cnt - d0), 64'd1);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    int            rpct;
    int            exp_count;
    int            exp_first;
  } vec_t;

  initial begin
    vec_t vecs [8];
    int   first;
    int   d0;
    int   g0;
    int   cyc;
    int   unstable;
    logic [15:0] vmask, dmask, bmask;
    logic [DW-1:0] held;

    vecs[0] = '{base: 0,   len: 4,   rpct: 100, exp_count: 4,   exp_first: 0};
    vecs[1] = '{base: 326, len: 4,   rpct: 100, exp_count: 4,   exp_first: 326};
    vecs[2] = '{base: 400, len: 3,   rpct: 100, exp_count: 3,   exp_first: 0};
    vecs[3] = '{base: 100, len: 1,   rpct: 60,  exp_count: 1,   exp_first: 100};
    vecs[4] = '{base: 327, len: 330, rpct: 100, exp_count: 330, exp_first: 327};
    vecs[5] = '{base: 50,  len: 7,   rpct: 50,  exp_count: 7,   exp_first: 50};
    vecs[6] = '{base: 10,  len: 511, rpct: 70,  exp_count: 511, exp_first: 10};
    vecs[7] = '{base: 5,   len: 0,   rpct: 100, exp_count: 0,   exp_first: 5};

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom | 32'h1;
    bus.out_ready = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset ram_address", 64'(bus.ram_address), 64'd0);
    check("reset out_data", 64'(bus.out_data), 64'd0);
    check("ram_wren", 64'(bus.ram_wren), 64'd0);
    check("ram_data", 64'(bus.ram_data), 64'd0);
    reset = 1'b0;
    tick();

    // ---------------- cycle-exact first run ----------------
    first = got.size();
    build_exp(0, 4);
    bus.out_ready = 1'b1;
    start = 1'b1; base_addr = 0; length = 4;
    vmask = '0; dmask = '0; bmask = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      start = 1'b0;
      vmask[i] = bus.out_valid;
      dmask[i] = done;
      bmask[i] = busy;
    end
    check("timing valid pattern", 64'(vmask), 64'h0924);
    check("timing done pattern", 64'(dmask), 64'h1000);
    check("timing busy pattern", 64'(bmask), 64'h1FFF);
    compare_words("timing", first);

    // ---------------- table-driven runs ----------------
    for (int v = 0; v < 8; v++) begin
      do_run($sformatf("vec%0d", v), vecs[v].base, vecs[v].len, vecs[v].rpct, 1'b0, first);
      check($sformatf("vec%0d count", v), 64'(got.size() - first), 64'(vecs[v].exp_count));
      if (got.size() > first)
        check($sformatf("vec%0d first word", v), 64'(got[first]), 64'(mem[vecs[v].exp_first]));
    end

    // ---------------- stall in HOLD ----------------
    first = got.size();
    build_exp(20, 5);
    bus.out_ready = 1'b0;
    start = 1'b1; base_addr = 20; length = 5;
    tick();
    start = 1'b0;
    check("stall ram_address", 64'(bus.ram_address), 64'd20);
    cyc = 0;
    while (!bus.out_valid && cyc < 10) begin tick(); cyc++; end
    check("stall valid seen", 64'(bus.out_valid), 64'd1);
    held = bus.out_data;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.out_valid || bus.out_data !== held) unstable++;
    end
    check("stall stable", 64'(unstable), 64'd0);
    bus.out_ready = 1'b1;
    cyc = 0;
    while (busy && cyc < 100) begin tick(); cyc++; end
    compare_words("stall", first);

    // ---------------- length 0 and start ignored while busy ----------------
    g0 = got.size();
    start = 1'b1; base_addr = 7; length = 0;
    tick();
    check("len0 done", 64'(done), 64'd1);
    check("len0 valid", 64'(bus.out_valid), 64'd0);
    length = 5;              // start still high while in DONE: must be ignored
    tick();
    start = 1'b0;
    check("len0 done cleared", 64'(done), 64'd0);
    check("start ignored busy", 64'(busy), 64'd0);
    tick(); tick(); tick();
    check("len0 no words", 64'(got.size() - g0), 64'd0);

    // ---------------- terminator word ----------------
    mem[5] = '0;
    do_run("term", 3, 10, 100, 1'b0, first);
    check("term count", 64'(got.size() - first), TERM_EN ? 64'd2 : 64'd10);
    mem[5] = $urandom | 32'h1;

    // ---------------- reset while holding a word ----------------
    bus.out_ready = 1'b0;
    start = 1'b1; base_addr = 0; length = 3;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 10) begin tick(); cyc++; end
    check("abort valid seen", 64'(bus.out_valid), 64'd1);
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("abort out_valid", 64'(bus.out_valid), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort out_data", 64'(bus.out_data), 64'd0);
    check("abort ram_address", 64'(bus.ram_address), 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("abort no done", 64'(done_cnt - d0), 64'd0);
    check("abort idle", 64'(busy), 64'd0);
    do_run("after abort", 12, 4, 100, 1'b0, first);

    // ---------------- randomized runs ----------------
    for (int r = 0; r < 8; r++) begin
      do_run($sformatf("rand%0d", r), AW'($urandom_range(0, 400)),
             $urandom_range(0, 40), $urandom_range(25, 100), 1'b1, first);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phrase_streamer.md
# phrase_streamer

Read-side sequencer for the 328×32 data RAM holding the preloaded phrase (`frase.dat`). On `start`, it walks a contiguous address range and presents each word to the downstream consumer (character/display logic) over a valid/ready handshake. It sits between the RAM's read port and that consumer. It drives `ram_wren` low so it can own the RAM port outright.

## Interface
Parameters:
- `DEPTH`, 328: number of RAM words; addresses 0..DEPTH-1.
- `DW`, 32: RAM and stream word width.
- `AW`, 32: RAM address width.
- `LEN_W`, 9: width of the `length` input.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request a new run; sampled only in IDLE.
- `base_addr` in AW: first word address; latched on accepted `start`.
- `length` in LEN_W: number of words to emit; latched on accepted `start`.
- `ram_address` out AW: registered address to the RAM.
- `ram_wren` out 1: constant 0.
- `ram_data` out DW: constant 0.
- `ram_q` in DW: RAM read data, valid one clock after the address edge.
- `out_data` out DW: streamed word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: the consumer accepts the word.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a run.

## Operation
States:
- **IDLE**
  - `start`=1 with `length`≠0: latch base and length, go to RD.
  - `start`=1 with `length`=0: go directly to DONE.
- **RD**: `ram_address` = current address; next state LATCH.
- **LATCH**
  - Register `ram_q` into `out_data`; next state HOLD.
  - With `PHRASE_STREAMER_TERM_EN`, see Configuration.
- **HOLD**
  - `out_valid`=1; `out_data` stays stable until the transfer.
  - On `out_valid && out_ready`: decrement the remaining count and advance the address.
  - Count reaches 0: go to DONE; otherwise go to RD.
- **DONE**: `done`=1 for one cycle; next state IDLE.

Address and width rules:
- The address advances as +1 with wrap-around: DEPTH-1 → 0.
- A latched `base_addr` ≥ DEPTH is replaced by 0.
- `length` > DEPTH is legal; the walk simply wraps.
- The remaining count is LEN_W bits and never underflows.

Other rules:
- `start` is ignored while `busy`=1.
- `base_addr` and `length` changes after acceptance have no effect on the current run.
- `out_ready` held low stalls indefinitely in HOLD; no timeout.

Reset values (also applied on `reset` asserted mid-run): state IDLE; `ram_address`, `out_data`, count all 0; `out_valid`, `busy`, `done` all 0. An in-flight word is discarded, and no `done` is produced for the aborted run.

## Timing
- `start` sampled high at edge N (IDLE → RD): `ram_address` is valid from edge N; `out_valid` rises after edge N+2.
- Minimum of 3 clocks per word with `out_ready` tied high.
- After the last transfer at edge M, `done` is high for the cycle after edge M; `busy` falls after edge M+1.
- Earliest next accepted `start`: edge M+2.
- `length`=0: `done` is high for the cycle after the `start` edge; `out_valid` never asserts.
- All outputs are registered; there is no combinational path from `out_ready` or `ram_q` to any output.

## Configuration
- `PHRASE_STREAMER_TERM_EN` defined:
  - In LATCH, a `ram_q` equal to all-zero is a terminator.
  - On a terminator, go to DONE without asserting `out_valid`. The terminator word is not emitted.
  - A run ends at the terminator or when `length` is exhausted, whichever comes first.
- Undefined:
  - Zero words are ordinary data and are emitted.
  - A run ends only when `length` is exhausted.

## Structure
- Package `phrase_streamer_pkg`:
  - State enum `ps_state_t` (IDLE, RD, LATCH, HOLD, DONE).
  - Constant `PS_RAM_DEPTH` = 328.
  - Terminator constant `PS_TERM_WORD` = 32'h0.
- Sub-module `phrase_addr_ctr`:
  - Loadable wrap-around address counter with clamp-to-0 on load ≥ DEPTH.
  - Used for both the load (IDLE) and advance (HOLD transfer) paths.

## Test plan
- Reset, then `start` with base=0, length=4, `out_ready`=1 → words at RAM[0..3] emitted in order; one word every 3 clocks; first `out_valid` after the 2nd edge following `start`; single `done` pulse.
- Base=326, length=4 → addresses 326, 327, 0, 1 are emitted.
- `out_ready` held low for 10 cycles mid-run → `out_valid` and `out_data` stay stable; no skipped or duplicated words.
- Length=0 → `done` on the next cycle; `out_valid` never asserts; `start` asserted during a run is ignored.
- With `PHRASE_STREAMER_TERM_EN`: RAM[5]=0, base=3, length=10 → only RAM[3] and RAM[4] emitted, then `done`. Without the macro, all 10 words are emitted, including the zero.
- `reset` asserted in HOLD → all outputs 0 immediately (async); no `done`; a fresh `start` runs normally.
